// File: rtl/i2s_serializer.sv
// Mono sample to I2S serializer: one-deep holding register, self-generated SCLK/LRCLK.
// Define I2S_LEFT_JUSTIFIED_EN for left-justified data mapping (MSB on the LRCLK edge).
module i2s_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int SCLK_DIV   = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] iv_din,
    input  logic                  i_din_valid,
    output logic                  o_ready,
    output logic                  o_sclk,
    output logic                  o_lrclk,
    output logic                  o_sdata,
    output logic                  o_underrun
);
    localparam int BCW = $clog2(2*SLOT_WIDTH);
    localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [BCW-1:0] BC_LAST  = BCW'(2*SLOT_WIDTH-1);
    localparam logic [BCW-1:0] BC_SLOT  = BCW'(SLOT_WIDTH);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(SCLK_DIV-1);

    typedef enum logic {S_EMPTY, S_FULL} hold_state_t;

    hold_state_t           state, state_nxt;
    logic [DATA_WIDTH-1:0] hold_reg, frame_reg, frame_nxt;
    logic [DCW-1:0]        div_cnt;
    logic [BCW-1:0]        bit_cnt, bit_cnt_nxt, k_nxt;
    logic                  fall, load, sdata_nxt;

    assign fall        = i_en && (div_cnt == DIV_LAST) && o_sclk;
    assign load        = fall && (bit_cnt == BC_LAST);
    assign bit_cnt_nxt = (bit_cnt == BC_LAST) ? '0 : bit_cnt + BCW'(1);
    assign k_nxt       = (bit_cnt_nxt >= BC_SLOT) ? bit_cnt_nxt - BC_SLOT : bit_cnt_nxt;
    assign o_ready     = (state == S_EMPTY);

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_EMPTY;
        else       state <= state_nxt;
    end

    // Load decision uses the pre-edge state, so an accept on a load cycle still underruns.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: if (i_din_valid) state_nxt = S_FULL;
            S_FULL:  if (load)        state_nxt = S_EMPTY;
            default:                  state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        frame_nxt = frame_reg;
        if (load) frame_nxt = (state == S_FULL) ? hold_reg : '0;
    end

    // Bit for the slot position being entered; uses frame_nxt so k=0 sees a fresh load.
    always_comb begin
        sdata_nxt = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
            if (k_nxt == BCW'(DATA_WIDTH-1-i)) sdata_nxt = frame_nxt[i];
`else
            if (k_nxt == BCW'(DATA_WIDTH-i)) sdata_nxt = frame_nxt[i];
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_reg   <= '0;
            frame_reg  <= '0;
            div_cnt    <= '0;
            bit_cnt    <= BC_LAST;
            o_sclk     <= 1'b0;
            o_lrclk    <= 1'b0;
            o_sdata    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= load && (state == S_EMPTY);
            if ((state == S_EMPTY) && i_din_valid) hold_reg <= iv_din;
            if (i_en) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    o_sclk  <= ~o_sclk;
                end else begin
                    div_cnt <= div_cnt + DCW'(1);
                end
            end
            if (fall) begin
                bit_cnt   <= bit_cnt_nxt;
                o_lrclk   <= (bit_cnt_nxt >= BC_SLOT);
                o_sdata   <= sdata_nxt;
                frame_reg <= frame_nxt;
            end
        end
    end
endmodule

// File: tb/tb_i2s_serializer.sv
// Bench for i2s_serializer: cycle-count reference model feeds a slot scoreboard;
// a negedge monitor deserializes SDATA on SCLK rises and pops expected slot words.
module tb_i2s_serializer;
    localparam int DW    = 24;
    localparam int SW    = 32;
    localparam int DIV   = 2;
    localparam int FRAME = 4*SW*DIV;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_en  = 1'b1;
    logic [DW-1:0] iv_din = '0;
    logic          i_din_valid = 1'b0;
    logic          o_ready, o_sclk, o_lrclk, o_sdata, o_underrun;

    i2s_serializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .SCLK_DIV(DIV)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .iv_din(iv_din),
        .i_din_valid(i_din_valid), .o_ready(o_ready), .o_sclk(o_sclk),
        .o_lrclk(o_lrclk), .o_sdata(o_sdata), .o_underrun(o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;

    function automatic logic [SW-1:0] slot_word(input logic [DW-1:0] s);
`ifdef I2S_LEFT_JUSTIFIED_EN
        slot_word = {s, {(SW-DW){1'b0}}};
`else
        slot_word = {1'b0, s, {(SW-DW-1){1'b0}}};
`endif
    endfunction

    // Reference model: frame loads every FRAME enabled cycles, first at enabled cycle 4.
    logic [DW-1:0] m_hold = '0;
    bit            m_full = 1'b0;
    int            ecount = 0;
    bit            exp_under = 1'b0;
    bit            mon_clr = 1'b1;
    logic [SW-1:0] exp_q[$];

    always @(posedge i_clk) begin
        bit full_pre, ld;
        if (i_rst) begin
            m_full = 1'b0; ecount = 0; exp_under = 1'b0; mon_clr = 1'b1;
            exp_q.delete();
        end else begin
            mon_clr = 1'b0; full_pre = m_full; ld = 1'b0; exp_under = 1'b0;
            if (i_en) begin
                ecount++;
                ld = (ecount % FRAME) == 4;
            end
            if (ld) begin
                if (full_pre) begin
                    exp_q.push_back(slot_word(m_hold));
                    exp_q.push_back(slot_word(m_hold));
                    m_full = 1'b0;
                end else begin
                    exp_q.push_back('0);
                    exp_q.push_back('0);
                    exp_under = 1'b1;
                end
            end
            if (!full_pre && i_din_valid) begin
                m_full = 1'b1;
                m_hold = iv_din;
            end
        end
    end

    // Monitor / scoreboard
    int            fcnt = 0;
    int            rx_slots = 0;
    logic [SW-1:0] rx_word = '0;
    logic          prev_sclk = 1'b0, prev_sdata = 1'b0;

    always @(negedge i_clk) begin
        logic [SW-1:0] e;
        logic exp_sclk, exp_lr, exp_rdy;
        if (mon_clr) begin
            fcnt = 0; rx_slots = 0; rx_word = '0;
            prev_sclk = o_sclk; prev_sdata = o_sdata;
        end else begin
            exp_rdy  = m_full ? 1'b0 : 1'b1;
            exp_sclk = ((ecount / DIV) % 2) == 1;
            checks++;
            if (o_ready !== exp_rdy) begin
                failures++; $display("FAIL ready t=%0t got=%b exp=%b", $time, o_ready, exp_rdy);
            end
            checks++;
            if (o_sclk !== exp_sclk) begin
                failures++; $display("FAIL sclk t=%0t got=%b exp=%b", $time, o_sclk, exp_sclk);
            end
            checks++;
            if (o_underrun !== exp_under) begin
                failures++; $display("FAIL underrun t=%0t got=%b exp=%b", $time, o_underrun, exp_under);
            end
            if (!prev_sclk && o_sclk && fcnt > 0) rx_word = {rx_word[SW-2:0], o_sdata};
            if (prev_sclk && !o_sclk) begin
                if (fcnt > 0 && fcnt % SW == 0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++; $display("FAIL slot_word t=%0t got=%h exp=<none>", $time, rx_word);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_word !== e) begin
                            failures++; $display("FAIL slot_word t=%0t got=%h exp=%h", $time, rx_word, e);
                        end
                    end
                    rx_slots++;
                end
                fcnt++;
                exp_lr = (((fcnt-1) / SW) % 2) == 1;
                checks++;
                if (o_lrclk !== exp_lr) begin
                    failures++; $display("FAIL lrclk t=%0t got=%b exp=%b", $time, o_lrclk, exp_lr);
                end
            end else if (o_sdata !== prev_sdata) begin
                checks++; failures++;
                $display("FAIL sdata_stable t=%0t got=%b exp=%b", $time, o_sdata, prev_sdata);
            end
            prev_sclk = o_sclk; prev_sdata = o_sdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Leaves the bench 1 time unit after "edge 0", the last edge with i_rst high.
    task automatic do_reset();
        i_rst = 1'b1; i_din_valid = 1'b0; i_en = 1'b1;
        tick(2);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(3);
        checks++;
        if ({o_sclk, o_lrclk, o_sdata, o_ready, o_underrun} !== 5'b00010) begin
            failures++; $display("FAIL reset_vals got=%b exp=00010", {o_sclk, o_lrclk, o_sdata, o_ready, o_underrun});
        end
        i_rst = 1'b0;
        tick(1);
        checks++; if (o_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk_c1 got=%b exp=0", o_sclk); end
        tick(1);
        checks++; if (o_sclk !== 1'b1) begin failures++; $display("FAIL reset_rise_c2 got=%b exp=1", o_sclk); end
        tick(2);
        checks++;
        if ({o_sclk, o_underrun, o_lrclk} !== 3'b010) begin
            failures++; $display("FAIL reset_fall_c4 got=%b exp=010", {o_sclk, o_underrun, o_lrclk});
        end
        tick(1);
        checks++; if (o_underrun !== 1'b0) begin failures++; $display("FAIL reset_under_c5 got=%b exp=0", o_underrun); end
    endtask

    task automatic test_single();
        do_reset();
        i_din_valid = 1'b1; iv_din = 24'hA50F3C;
        tick(1);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL single_ready_drop got=%b exp=0", o_ready); end
        i_din_valid = 1'b0;
        tick(3);
        checks++;
        if ({o_ready, o_underrun} !== 2'b10) begin
            failures++; $display("FAIL single_load got=%b exp=10", {o_ready, o_underrun});
        end
        tick(255);
        checks++; if (rx_slots !== 1) begin failures++; $display("FAIL single_slots got=%0d exp=1", rx_slots); end
    endtask

    // Continues straight from test_single at edge 259.
    task automatic test_starvation();
        int pulses;
        tick(1);
        checks++; if (o_underrun !== 1'b1) begin failures++; $display("FAIL starve_under got=%b exp=1", o_underrun); end
        pulses = 0;
        for (int i = 0; i < 255; i++) begin
            tick(1);
            if (o_underrun) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL starve_extra_pulses got=%0d exp=0", pulses); end
        tick(2);
        checks++; if (rx_slots !== 4) begin failures++; $display("FAIL starve_slots got=%0d exp=4", rx_slots); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        i_din_valid = 1'b1; iv_din = 24'h800000;
        tick(1);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_drop got=%b exp=0", o_ready); end
        n = 1;
        while (!o_ready && n < 300) begin
            tick(1);
            n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL b2b_ready_return_cycle got=%0d exp=4", n); end
        iv_din = 24'h7FFFFF;
        tick(1);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got=%b exp=0", o_ready); end
        i_din_valid = 1'b0;
        tick(513);
        checks++; if (rx_slots !== 4) begin failures++; $display("FAIL b2b_slots got=%0d exp=4", rx_slots); end
    endtask

    task automatic test_collision();
        do_reset();
        tick(259);
        i_din_valid = 1'b1; iv_din = 24'h123456;
        tick(1);
        checks++;
        if ({o_underrun, o_ready} !== 2'b10) begin
            failures++; $display("FAIL collide_load got=%b exp=10", {o_underrun, o_ready});
        end
        i_din_valid = 1'b0;
        tick(516);
        checks++; if (rx_slots !== 6) begin failures++; $display("FAIL collide_slots got=%0d exp=6", rx_slots); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_din_valid = 1'b1; iv_din = 24'hFFFFFF;
        tick(1);
        i_din_valid = 1'b0;
        tick(163);
        checks++; if (rx_slots !== 1) begin failures++; $display("FAIL rstmid_pre_slots got=%0d exp=1", rx_slots); end
        i_rst = 1'b1;
        tick(1);
        checks++;
        if ({o_sclk, o_lrclk, o_sdata, o_ready, o_underrun} !== 5'b00010) begin
            failures++; $display("FAIL rstmid_vals got=%b exp=00010", {o_sclk, o_lrclk, o_sdata, o_ready, o_underrun});
        end
        i_rst = 1'b0;
        tick(2);
        checks++; if (o_sclk !== 1'b1) begin failures++; $display("FAIL rstmid_rise got=%b exp=1", o_sclk); end
        tick(2);
        checks++;
        if ({o_sclk, o_underrun} !== 2'b01) begin
            failures++; $display("FAIL rstmid_first_load got=%b exp=01", {o_sclk, o_underrun});
        end
    endtask

    task automatic test_enable();
        logic [2:0] held;
        int bad;
        do_reset();
        tick(6);
        i_en = 1'b0;
        held = {o_sclk, o_lrclk, o_sdata};
        i_din_valid = 1'b1; iv_din = 24'h3C3C3C;
        tick(1);
        checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL en_handshake got=%b exp=0", o_ready); end
        i_din_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if ({o_sclk, o_lrclk, o_sdata} !== held) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL en_freeze got=%0d exp=0", bad); end
        i_en = 1'b1;
        tick(540);
        checks++; if (rx_slots !== 4) begin failures++; $display("FAIL en_slots got=%0d exp=4", rx_slots); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_starvation();
        test_back_to_back();
        test_collision();
        test_reset_mid();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
